// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, load/store port and RAM port seen by mem_arbiter.
interface mem_arbiter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic        i_resp_valid;
    logic [31:0] i_rdata;

    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        d_resp_valid;
    logic [31:0] d_rdata;

    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport slave (
        input  i_valid, i_addr,
        output i_ready, i_resp_valid, i_rdata,
        input  d_valid, d_addr, d_we, d_wstrb, d_wdata,
        output d_ready, d_resp_valid, d_rdata,
        output ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output i_valid, i_addr,
        input  i_ready, i_resp_valid, i_rdata,
        output d_valid, d_addr, d_we, d_wstrb, d_wdata,
        input  d_ready, d_resp_valid, d_rdata,
        input  ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store onto one synchronous-read RAM; data has priority, fetch is forced
// through after MAX_STARVE contended data grants. Reads respond next cycle; partial stores do read-modify-write.
module mem_arbiter #(
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        iresp_q, iresp_d;
    logic        dresp_q, dresp_d;
    logic [31:0] rmw_addr_q, rmw_addr_d;
    logic [31:0] rmw_wdata_q, rmw_wdata_d;
    logic [3:0]  rmw_wstrb_q, rmw_wstrb_d;
    logic [31:0] port_addr_q, port_din_q;

    logic        port_we;
    logic [31:0] port_addr;
    logic [31:0] port_din;
    logic [31:0] merged;
    logic        i_gnt, d_gnt;
    logic        fetch_turn;

    // Strobed bytes come from the saved store data, the rest from the word read last cycle.
    always_comb begin
        merged = bus.ram_dout;
        for (int n = 0; n < 4; n++) begin
            if (rmw_wstrb_q[n]) begin
                merged[8*n +: 8] = rmw_wdata_q[8*n +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        iresp_d     = 1'b0;
        dresp_d     = 1'b0;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_wstrb_d = rmw_wstrb_q;
        port_we     = 1'b0;
        port_addr   = port_addr_q;
        port_din    = port_din_q;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        fetch_turn  = bus.i_valid && bus.d_valid && (starve_q == STARVE_LIM);

        case (state_q)
            IDLE: begin
                if (!rst) begin
                    d_gnt = bus.d_valid && !fetch_turn;
                    i_gnt = bus.i_valid && !d_gnt;
                end
                if (i_gnt) begin
                    port_addr = bus.i_addr;
                    iresp_d   = 1'b1;
                end
                if (d_gnt) begin
                    port_addr = bus.d_addr;
                    if (!bus.d_we || bus.d_wstrb == 4'h0) begin
                        dresp_d = 1'b1;
                    end else if (bus.d_wstrb == 4'hF) begin
                        port_we  = 1'b1;
                        port_din = bus.d_wdata;
                        dresp_d  = 1'b1;
                    end else begin
                        rmw_addr_d  = bus.d_addr;
                        rmw_wdata_d = bus.d_wdata;
                        rmw_wstrb_d = bus.d_wstrb;
                        state_d     = RMW_WR;
                    end
                end
                if (!bus.i_valid || i_gnt) begin
                    starve_d = 4'd0;
                end else if (d_gnt) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            RMW_WR: begin
                port_we   = 1'b1;
                port_addr = rmw_addr_q;
                port_din  = merged;
                dresp_d   = 1'b1;
                state_d   = IDLE;
                if (!bus.i_valid) begin
                    starve_d = 4'd0;
                end
            end
        endcase

        // A write caught by reset must never reach the array.
        if (rst) begin
            port_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            iresp_q     <= 1'b0;
            dresp_q     <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_wdata_q <= '0;
            rmw_wstrb_q <= '0;
            port_addr_q <= '0;
            port_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            iresp_q     <= iresp_d;
            dresp_q     <= dresp_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_wdata_q <= rmw_wdata_d;
            rmw_wstrb_q <= rmw_wstrb_d;
            port_addr_q <= port_addr;
            port_din_q  <= port_din;
        end
    end

    assign bus.i_ready      = i_gnt;
    assign bus.d_ready      = d_gnt;
    assign bus.i_resp_valid = iresp_q;
    assign bus.d_resp_valid = dresp_q;
    assign bus.i_rdata      = bus.ram_dout;
    assign bus.d_rdata      = bus.ram_dout;
    assign bus.ram_we       = port_we;
    assign bus.ram_addr     = port_addr;
    assign bus.ram_din      = port_din;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port, synchronous-read 4 KB `ram` between the instruction-fetch port and the load/store port of the CPU. Each cycle it grants at most one request, drives the RAM port combinationally from the winner, and routes the one-cycle-later read data back to the winner. Byte-strobed stores are done as read-modify-write, since the RAM has only a full-word write enable. It sits between the core's two memory interfaces and the `ram` instance.

## Interface
- `MAX_STARVE`, default 4: maximum consecutive contended grants to data before fetch is forced through (1..15).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` in 1 / `i_ready` out 1 / `i_addr` in 32: fetch request handshake and address (read-only).
- `i_resp_valid` out 1 / `i_rdata` out 32: fetch response pulse and word.
- `d_valid` in 1 / `d_ready` out 1 / `d_addr` in 32: data request handshake and address.
- `d_we` in 1 / `d_wstrb` in 4 / `d_wdata` in 32: store flag, byte strobes (bit n = byte n), write data.
- `d_resp_valid` out 1 / `d_rdata` out 32: data response pulse; read word (loads), don't-care for stores.
- `ram_we` out 1 / `ram_addr` out 32 / `ram_din` out 32: to RAM; only `addr[11:2]` is used by the RAM.
- `ram_dout` in 32: RAM registered read data, valid the cycle after the address is issued.

## Operation
- States: IDLE (port free), RMW_WR (merged write owns the port). Registered: state, response owner/type, RMW address/wdata/wstrb, starvation counter (4 bits).
- Request accepted on `valid && ready`. A requester holds its address and data stable until accepted. There is no response backpressure.
- IDLE: `i_ready`/`d_ready` follow arbitration. RMW_WR: both readies are 0, and the port issues `ram_we=1`, `ram_addr`=saved address, `ram_din` = per byte (`wstrb[n]` ? saved wdata byte : `ram_dout` byte). Then back to IDLE.
- Arbitration in IDLE:
  - Data has priority.
  - If both are valid and the counter equals `MAX_STARVE`, fetch wins and the counter clears.
  - The counter increments on each contended data grant, and clears when fetch is granted or `i_valid`=0.
- Op decode for an accepted data request:
  - `d_we=0`: read.
  - `d_we=1, wstrb=4'hF`: full write.
  - `d_we=1, wstrb=0`: no-op store. Acked with no RAM write.
  - Other strobes: RMW. The read is issued in the accept cycle, then the state goes to RMW_WR.
- Fetch `i_addr[1:0]` is ignored. For data, `d_addr[1:0]` is ignored: word addressing only, with alignment handled by the core.
- `ram_we` is forced to 0 whenever `rst`=1, so a write aborted by reset never reaches the RAM.
- With no grant, `ram_we`=0 and `ram_addr`/`ram_din` hold their last value. Only `ram_we` is guaranteed.

## Timing
- Read (fetch or load) accepted in cycle T → `*_resp_valid`=1 in T+1 with `*_rdata`=`ram_dout`.
- Full write or no-op store accepted in T → write issued in T → `d_resp_valid` in T+1.
- RMW accepted in T: read in T, merged write in T+1 (RMW_WR, readies 0), `d_resp_valid` in T+2.
- Throughput: one read/full write per cycle. A new request may be accepted in the same cycle as the previous response. RMW costs 2 port cycles.
- `*_resp_valid` is a single-cycle pulse per accepted request, and only to the granted port. `*_rdata` is undefined when its valid is 0.
- Reset values (in the cycle after `rst` is sampled high, and while high):
  - state IDLE, counter 0.
  - `i_resp_valid`=`d_resp_valid`=0.
  - `i_ready`=`d_ready`=0 while `rst`=1.
  - `ram_we`=0.
  - Responses pending at reset are dropped.
- Reset during RMW_WR: no write occurs, and no response is given.
- Simultaneous valids: exactly one ready is high in a given cycle. The loser's ready is 0, and it must hold its request.

## Test plan
- Preload RAM word 0 = 0x026281b3. Fetch `i_addr`=0 accepted at T → `i_resp_valid` at T+1, `i_rdata`=0x026281b3, `d_resp_valid`=0.
- Back-to-back loads at addresses 0x4, 0x8 in consecutive cycles → both accepted without a bubble. Responses in consecutive cycles carry the matching words.
- Word 0x10 = 0x11223344. Store `wstrb`=4'b0110, `wdata`=0xAABBCCDD:
  - `d_ready`=0 in T+1.
  - `ram_we` in T+1 with `ram_din`=0x11BBCC44.
  - `d_resp_valid` at T+2.
  - A subsequent load of 0x10 returns 0x11BBCC44.
- `i_valid` and `d_valid` held high continuously, `MAX_STARVE`=4 → data wins 4 cycles, fetch wins the 5th, and the pattern repeats. Never more than 4 consecutive data grants.
- Store with `wstrb`=0 → acked at T+1, `ram_we` never asserted, memory unchanged. Store with 4'hF → single write cycle.
- Assert `rst` in the RMW_WR cycle → `ram_we`=0, target word unchanged, no `d_resp_valid`. Both readies are 0 during reset, and normal operation resumes the cycle after `rst` drops.
